// File: rtl/core_pkg.sv
// Shared core constants and the fetch payload type used by the front end.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: streams sequential words from a synchronous imem,
// with a single-entry skid buffer for decode back-pressure and redirect flush.
module ifetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-3:0] imem_pc,
  input  logic [ILEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst
);

  logic [XLEN-1:0] f_q, f_d;
  logic [XLEN-1:0] r_q, r_d;
  logic            v_q, v_d;
  logic            h_valid_q, h_valid_d;
  fetch_pkt_t      h_q, h_d;

  // While holding, re-read R so its word is on imem_inst the cycle after drain.
  assign imem_pc   = h_valid_q ? r_q[XLEN-1:2] : f_q[XLEN-1:2];

  assign out_valid = h_valid_q | v_q;
  assign out_pc    = h_valid_q ? h_q.pc   : r_q;
  assign out_inst  = h_valid_q ? h_q.inst : imem_inst;

  // Next-state: redirect flushes everything; otherwise advance, capture or drain.
  always_comb begin
    f_d       = f_q;
    r_d       = r_q;
    v_d       = v_q;
    h_valid_d = h_valid_q;
    h_d       = h_q;

    if (redirect_valid) begin
      f_d       = word_align(redirect_pc);
      v_d       = 1'b0;
      h_valid_d = 1'b0;
    end else if (h_valid_q) begin
      if (out_ready) begin
        h_valid_d = 1'b0;
      end
    end else begin
      if (v_q && !out_ready) begin
        h_d.pc    = r_q;
        h_d.inst  = imem_inst;
        h_valid_d = 1'b1;
      end
      r_d = f_q;
      v_d = 1'b1;
      f_d = f_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q       <= RESET_PC;
      r_q       <= '0;
      v_q       <= 1'b0;
      h_valid_q <= 1'b0;
      h_q       <= '0;
    end else begin
      f_q       <= f_d;
      r_q       <= r_d;
      v_q       <= v_d;
      h_valid_q <= h_valid_d;
      h_q       <= h_d;
    end
  end

endmodule
